// File: rtl/intersection_pkg.sv
// ------------------------------------------------------------
// intersection_pkg: phase encoding, default durations, timer sizing
// Revision: 1.0
// ------------------------------------------------------------
`default_nettype none

package intersection_pkg;

   typedef enum logic [2:0] {
      MAIN_G = 3'd0,
      MAIN_Y = 3'd1,
      MAIN_R = 3'd2,
      TURN_G = 3'd3,
      TURN_Y = 3'd4,
      TURN_R = 3'd5,
      PED_G  = 3'd6,
      PED_R  = 3'd7
   } phase_t;

   localparam int LIVENESS_BOUND   = 50;
   localparam int DEF_MIN_GREEN    = 8;
   localparam int DEF_SERVE_TIME   = 6;
   localparam int DEF_YELLOW_TIME  = 3;
   localparam int DEF_ALL_RED_TIME = 2;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int timer_width(input int max_duration);
      return $clog2(max_duration) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// ------------------------------------------------------------
// phase_timer: loadable down-counter that holds at zero
// Revision: 1.0
// ------------------------------------------------------------
`default_nettype none

module phase_timer #(
   parameter int               WIDTH      = 4,
   parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value,
   output logic             done
);

   always_ff @(posedge clock) begin
      if (reset) begin
         value <= INIT_VALUE;
      end else if (load) begin
         value <= load_value;
      end else if (value != '0) begin
         value <= value - WIDTH'(1);
      end
   end

   assign done = (value == '0);

endmodule

`default_nettype wire

// File: rtl/phase_sequencer.sv
// ------------------------------------------------------------
// phase_sequencer: main green with arbitrated turn/pedestrian service
// Revision: 1.0
// ------------------------------------------------------------
`default_nettype none

module phase_sequencer
   import intersection_pkg::*;
#(
   parameter int MIN_GREEN    = DEF_MIN_GREEN,
   parameter int SERVE_TIME   = DEF_SERVE_TIME,
   parameter int YELLOW_TIME  = DEF_YELLOW_TIME,
   parameter int ALL_RED_TIME = DEF_ALL_RED_TIME
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pedestrian_button,
   input  logic       turn_sensor,
   output logic       up_green,
   output logic       up_yellow,
   output logic       down_green,
   output logic       down_yellow,
   output logic       turn_green,
   output logic       turn_yellow,
   output logic       pedestrian_green,
   output logic [2:0] phase
);

   localparam int TIMER_W = timer_width(max_of(max_of(MIN_GREEN, SERVE_TIME),
                                               YELLOW_TIME + ALL_RED_TIME));
   localparam int REQ_TO_GREEN = 1 + (SERVE_TIME + YELLOW_TIME + ALL_RED_TIME)
                                   + (MIN_GREEN + YELLOW_TIME + ALL_RED_TIME) + 1;
   localparam int UD_GAP       = 2 * (YELLOW_TIME + ALL_RED_TIME) + SERVE_TIME;

   if (REQ_TO_GREEN > LIVENESS_BOUND || UD_GAP > LIVENESS_BOUND) begin : g_liveness_fail
      $fatal(1, "phase_sequencer: worst-case latency exceeds LIVENESS_BOUND");
   end

   phase_t               state, next_state;
   logic [TIMER_W-1:0]   timer_value, load_value;
   logic                 timer_done, timer_load;
   logic                 ped_pend, turn_pend;
   logic                 ped_req, turn_req;
   logic                 enter_ped, enter_turn;
   logic                 sel_turn, last_turn;

   function automatic logic [TIMER_W-1:0] reload(input phase_t s);
      case (s)
         MAIN_G:  reload = TIMER_W'(MIN_GREEN - 1);
         MAIN_Y:  reload = TIMER_W'(YELLOW_TIME - 1);
         MAIN_R:  reload = TIMER_W'(ALL_RED_TIME - 1);
         TURN_G:  reload = TIMER_W'(SERVE_TIME - 1);
         TURN_Y:  reload = TIMER_W'(YELLOW_TIME - 1);
         TURN_R:  reload = TIMER_W'(ALL_RED_TIME - 1);
         PED_G:   reload = TIMER_W'(SERVE_TIME - 1);
         PED_R:   reload = TIMER_W'(YELLOW_TIME + ALL_RED_TIME - 1);
         default: reload = TIMER_W'(MIN_GREEN - 1);
      endcase
   endfunction

   phase_timer #(
      .WIDTH      (TIMER_W),
      .INIT_VALUE (TIMER_W'(MIN_GREEN - 1))
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (timer_load),
      .load_value (load_value),
      .value      (timer_value),
      .done       (timer_done)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= MAIN_G;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         MAIN_G:  if (timer_done && (ped_pend || turn_pend)) next_state = MAIN_Y;
         MAIN_Y:  if (timer_done) next_state = MAIN_R;
         MAIN_R:  if (timer_done) next_state = sel_turn ? TURN_G : PED_G;
         TURN_G:  if (timer_done) next_state = TURN_Y;
         TURN_Y:  if (timer_done) next_state = TURN_R;
         TURN_R:  if (timer_done) next_state = MAIN_G;
         PED_G:   if (timer_done) next_state = PED_R;
         PED_R:   if (timer_done) next_state = MAIN_G;
         default: next_state = MAIN_G;
      endcase
   end

   // Every transition changes state, so a state change is exactly a phase entry.
   assign timer_load = (next_state != state);
   assign load_value = reload(next_state);

   // A request is ignored while its own green runs, except in that green's last cycle.
   assign ped_req    = pedestrian_button & ((state != PED_G)  | (timer_value == '0));
   assign turn_req   = turn_sensor       & ((state != TURN_G) | (timer_value == '0));
   assign enter_ped  = (next_state == PED_G)  && (state != PED_G);
   assign enter_turn = (next_state == TURN_G) && (state != TURN_G);

   always_ff @(posedge clock) begin
      if (reset) begin
         ped_pend  <= 1'b0;
         turn_pend <= 1'b0;
         sel_turn  <= 1'b0;
         last_turn <= 1'b1;
      end else begin
         ped_pend  <= (ped_pend  | ped_req)  & ~enter_ped;
         turn_pend <= (turn_pend | turn_req) & ~enter_turn;
         if (state == MAIN_G && next_state == MAIN_Y) begin
            sel_turn <= turn_pend & (~ped_pend | ~last_turn);
         end
         if (enter_turn) begin
            last_turn <= 1'b1;
         end else if (enter_ped) begin
            last_turn <= 1'b0;
         end
      end
   end

   always_comb begin
      up_green         = 1'b0;
      up_yellow        = 1'b0;
      down_green       = 1'b0;
      down_yellow      = 1'b0;
      turn_green       = 1'b0;
      turn_yellow      = 1'b0;
      pedestrian_green = 1'b0;
      case (state)
         MAIN_G: begin
            up_green   = 1'b1;
            down_green = 1'b1;
         end
         MAIN_Y: begin
            up_yellow   = 1'b1;
            down_yellow = 1'b1;
         end
         TURN_G:  turn_green       = 1'b1;
         TURN_Y:  turn_yellow      = 1'b1;
         PED_G:   pedestrian_green = 1'b1;
         default: ;
      endcase
   end

   assign phase = state;

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// ------------------------------------------------------------
// tb_phase_sequencer: scoreboard bench with hand-derived phase timelines
// Revision: 1.0
// ------------------------------------------------------------
`default_nettype none

module tb_phase_sequencer;
   import intersection_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       pedestrian_button = 1'b0;
   logic       turn_sensor = 1'b0;
   logic       up_green, up_yellow, down_green, down_yellow;
   logic       turn_green, turn_yellow, pedestrian_green;
   logic [2:0] phase;

   typedef struct {
      int     cyc;
      phase_t ph;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   phase_sequencer dut (
      .clock             (clock),
      .reset             (reset),
      .pedestrian_button (pedestrian_button),
      .turn_sensor       (turn_sensor),
      .up_green          (up_green),
      .up_yellow         (up_yellow),
      .down_green        (down_green),
      .down_yellow       (down_yellow),
      .turn_green        (turn_green),
      .turn_yellow       (turn_yellow),
      .pedestrian_green  (pedestrian_green),
      .phase             (phase)
   );

   always #5 clock = ~clock;

   // Cycle k is the interval after edge k; the edge that samples reset is edge 0.
   always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

   // Lamp order: up_g up_y down_g down_y turn_g turn_y ped_g
   function automatic logic [6:0] lamps_of(input phase_t p);
      case (p)
         MAIN_G:  return 7'b1010000;
         MAIN_Y:  return 7'b0101000;
         TURN_G:  return 7'b0000100;
         TURN_Y:  return 7'b0000010;
         PED_G:   return 7'b0000001;
         default: return 7'b0000000;
      endcase
   endfunction

   // Steady-state schedule with both requests held, k = (cycle-8) mod 48.
   function automatic phase_t steady(input int k);
      if (k < 3)       return MAIN_Y;
      else if (k < 5)  return MAIN_R;
      else if (k < 11) return PED_G;
      else if (k < 16) return PED_R;
      else if (k < 24) return MAIN_G;
      else if (k < 27) return MAIN_Y;
      else if (k < 29) return MAIN_R;
      else if (k < 35) return TURN_G;
      else if (k < 38) return TURN_Y;
      else if (k < 40) return TURN_R;
      else             return MAIN_G;
   endfunction

   always @(negedge clock) begin
      if (!reset && exp_q.size() > 0) begin
         if (exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missed@%0d got_cycle=%0d want_cycle=%0d", mon_e.cyc, cyc, mon_e.cyc);
         end else if (exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            total++;
            if (phase !== mon_e.ph) begin
               bad++;
               $display("FAIL phase@%0d got=%0d want=%0d", cyc, phase, mon_e.ph);
            end
            total++;
            if ({up_green, up_yellow, down_green, down_yellow, turn_green, turn_yellow,
                 pedestrian_green} !== lamps_of(mon_e.ph)) begin
               bad++;
               $display("FAIL lamps@%0d got=%b want=%b", cyc,
                        {up_green, up_yellow, down_green, down_yellow, turn_green,
                         turn_yellow, pedestrian_green}, lamps_of(mon_e.ph));
            end
         end
      end
   end

   task automatic exp_seg(input int lo, input int hi, input phase_t ph);
      for (int c = lo; c <= hi; c++) exp_q.push_back('{cyc: c, ph: ph});
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      int guard = 0;
      while (cyc != n && guard < 1000) begin
         @(posedge clock);
         #1;
         guard++;
      end
      if (cyc != n) begin
         total++;
         bad++;
         $display("FAIL wait_cyc got=%0d want=%0d", cyc, n);
      end
   endtask

   // Input high so that it is sampled at edge n, low again afterwards.
   task automatic pulse(input logic ped, input logic trn, input int n);
      wait_cyc(n - 1);
      pedestrian_button = ped;
      turn_sensor       = trn;
      @(posedge clock);
      #1;
      pedestrian_button = 1'b0;
      turn_sensor       = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() > 0 && guard < 2000) begin
         @(posedge clock);
         #1;
         guard++;
      end
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain got=%0d want=0 pending", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap, max_gap, overlaps;

      // Idle: main green forever.
      apply_reset();
      exp_seg(0, 99, MAIN_G);
      drain();

      // Single pedestrian pulse at edge 20.
      apply_reset();
      exp_seg(0, 20, MAIN_G);
      exp_seg(21, 23, MAIN_Y);
      exp_seg(24, 25, MAIN_R);
      exp_seg(26, 31, PED_G);
      exp_seg(32, 36, PED_R);
      exp_seg(37, 40, MAIN_G);
      pulse(1'b1, 1'b0, 20);
      drain();

      // Pedestrian pulse during minimum green.
      apply_reset();
      exp_seg(0, 7, MAIN_G);
      exp_seg(8, 10, MAIN_Y);
      exp_seg(11, 12, MAIN_R);
      exp_seg(13, 13, PED_G);
      pulse(1'b1, 1'b0, 2);
      drain();

      // Simultaneous requests: pedestrian first, then turn.
      apply_reset();
      exp_seg(0, 20, MAIN_G);
      exp_seg(21, 23, MAIN_Y);
      exp_seg(24, 25, MAIN_R);
      exp_seg(26, 31, PED_G);
      exp_seg(32, 36, PED_R);
      exp_seg(37, 44, MAIN_G);
      exp_seg(45, 47, MAIN_Y);
      exp_seg(48, 49, MAIN_R);
      exp_seg(50, 55, TURN_G);
      exp_seg(56, 58, TURN_Y);
      exp_seg(59, 60, TURN_R);
      exp_seg(61, 64, MAIN_G);
      pulse(1'b1, 1'b1, 20);
      drain();

      // Reset in the middle of a pedestrian green.
      apply_reset();
      exp_seg(0, 7, MAIN_G);
      exp_seg(8, 10, MAIN_Y);
      exp_seg(11, 12, MAIN_R);
      exp_seg(13, 13, PED_G);
      pulse(1'b1, 1'b0, 2);
      drain();
      total++;
      if (phase !== 3'(PED_G)) begin
         bad++;
         $display("FAIL pre_reset_phase got=%0d want=%0d", phase, PED_G);
      end
      apply_reset();
      exp_seg(0, 20, MAIN_G);
      drain();

      // Both requests held: alternating service with bounded main-green gaps.
      apply_reset();
      exp_seg(0, 7, MAIN_G);
      for (int c = 8; c < 300; c++) exp_q.push_back('{cyc: c, ph: steady((c - 8) % 48)});
      pedestrian_button = 1'b1;
      turn_sensor       = 1'b1;
      gap      = 0;
      max_gap  = 0;
      overlaps = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clock);
         #1;
         if (up_green && down_green) gap = 0;
         else gap++;
         if (gap > max_gap) max_gap = gap;
         if (int'(up_green | down_green) + int'(turn_green) + int'(pedestrian_green) > 1)
            overlaps++;
      end
      drain();
      pedestrian_button = 1'b0;
      turn_sensor       = 1'b0;
      total++;
      if (max_gap != 16) begin
         bad++;
         $display("FAIL ud_gap got=%0d want=16", max_gap);
      end
      total++;
      if (overlaps != 0) begin
         bad++;
         $display("FAIL green_overlap got=%0d want=0", overlaps);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
